// File: rtl/kws_hit_confirm.sv
// kws_hit_confirm: keyword hit confirmation stage behind the DP-matching decision.
// Confirms a keyword after HIT_MIN rising edges of `result`. Consecutive edges may be
// at most GAP_MAX cycles apart, and all of them must fall inside one VAD segment.
// A confirmation produces a one-cycle detect_pulse and holds detect_led high for
// HOLD_CYCLES cycles. Further detections are then locked out until the VAD segment ends.
// Optional feature macro: KWS_DET_CNT_EN. When it is defined, det_cnt_o counts
// detections and saturates at 16'hFFFF. When it is undefined, det_cnt_o is tied to zero.
module kws_hit_confirm #(
  parameter int BIT         = 32,
  parameter int HIT_MIN     = 2,
  parameter int GAP_MAX     = 500000,
  parameter int HOLD_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              result,
  input  logic              vad_in,
  input  logic [BIT+12:0]   scr_i,
  input  logic [6:0]        len_i,
  output logic              detect_pulse,
  output logic              detect_led,
  output logic [1:0]        state_o,
  output logic [BIT+12:0]   hit_scr_o,
  output logic [6:0]        hit_len_o,
  output logic [15:0]       det_cnt_o
);

  localparam int HIT_W  = $clog2(HIT_MIN + 1);
  localparam int GAP_W  = $clog2(GAP_MAX + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  // Last count value before a hit confirms, the window expires, or the hold ends.
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(HIT_MIN - 1);
  localparam logic [HIT_W-1:0]  HIT_SAT   = HIT_W'(HIT_MIN);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    HOLD     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic                result_q;
  logic [HIT_W-1:0]    hit_cnt_reg, hit_cnt_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                pulse_reg, pulse_next;
  logic                led_reg, led_next;
  logic [BIT+12:0]     hit_scr_reg, hit_scr_next;
  logic [6:0]          hit_len_reg, hit_len_next;
  logic                hit;

  // A hit is a rising edge of the DP match level, so a held-high result counts once.
  assign hit = result & ~result_q;

  // State and datapath registers. The edge detector runs in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      result_q     <= 1'b0;
      hit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      pulse_reg    <= 1'b0;
      led_reg      <= 1'b0;
      hit_scr_reg  <= '0;
      hit_len_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      result_q     <= result;
      hit_cnt_reg  <= hit_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      pulse_reg    <= pulse_next;
      led_reg      <= led_next;
      hit_scr_reg  <= hit_scr_next;
      hit_len_reg  <= hit_len_next;
    end
  end

  // Next-state logic: arm on VAD, count spaced edges, confirm, hold the LED, then lock out.
  always_comb begin
    state_next    = state_reg;
    hit_cnt_next  = hit_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    pulse_next    = 1'b0;
    led_next      = led_reg;
    hit_scr_next  = hit_scr_reg;
    hit_len_next  = hit_len_reg;

    case (state_reg)
      IDLE: begin
        led_next = 1'b0;
        if (vad_in) begin
          state_next   = ARMED;
          hit_cnt_next = '0;
          gap_cnt_next = '0;
        end
      end

      ARMED: begin
        if (!vad_in) begin
          // The segment has ended. Any edge seen in this same cycle is discarded.
          state_next   = IDLE;
          hit_cnt_next = '0;
          gap_cnt_next = '0;
        end else if (hit && (hit_cnt_reg >= HIT_LAST)) begin
          state_next    = HOLD;
          hit_cnt_next  = HIT_SAT;
          gap_cnt_next  = '0;
          hold_cnt_next = '0;
          pulse_next    = 1'b1;
          led_next      = 1'b1;
          hit_scr_next  = scr_i;
          hit_len_next  = len_i;
        end else if (hit) begin
          hit_cnt_next = hit_cnt_reg + 1'b1;
          gap_cnt_next = '0;
        end else if (hit_cnt_reg != '0) begin
          if (gap_cnt_reg == GAP_LAST) begin
            // The window has expired, so counting starts again from the next edge.
            hit_cnt_next = '0;
            gap_cnt_next = '0;
          end else begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
          end
        end
      end

      HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          led_next   = 1'b0;
          state_next = vad_in ? COOLDOWN : IDLE;
        end else begin
          led_next      = 1'b1;
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end

      COOLDOWN: begin
        if (!vad_in) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign detect_pulse = pulse_reg;
  assign detect_led   = led_reg;
  assign state_o      = state_reg;
  assign hit_scr_o    = hit_scr_reg;
  assign hit_len_o    = hit_len_reg;

`ifdef KWS_DET_CNT_EN
  logic [15:0] det_cnt_reg;

  // Saturating detection counter. It advances once per strobe and is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_cnt_reg <= '0;
    end else if (pulse_reg && (det_cnt_reg != 16'hFFFF)) begin
      det_cnt_reg <= det_cnt_reg + 16'd1;
    end
  end

  assign det_cnt_o = det_cnt_reg;
`else
  assign det_cnt_o = 16'd0;
`endif

endmodule
